i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- 7-bit-address I2C target (slave) that answers the team's i2c_master on the shared open-drain SCL/SDA pair.
- Detects START, repeated START and STOP, and matches the address byte against parameter ADDR.
- On a write transfer, delivers each received byte to user logic.
- On a read transfer, fetches each byte from user logic and shifts it out.
- No clock stretching; all logic runs on the system clock and oversamples the bus.

Parameters:
- ADDR, 7'h42, own 7-bit target address.
- SYNC_STAGES, 2, flip-flop stages on each of SCL and SDA before edge detection (minimum 2).

Ports:
- clk_i  input  1  system clock; at least 16x SCL frequency.
- rst_i  input  1  reset, asynchronous, active-high.
- scl_io  inout  1  I2C clock; input only, never driven by this block.
- sda_io  inout  1  I2C data; driven open-drain (0 or 'z' only).
- tx_data_i  input  8  read byte to send to the master; captured as defined under Behaviour.
- tx_req_o  output  1  one-cycle pulse requesting the next read byte.
- rx_data_o  output  8  last byte written by the master.
- rx_valid_o  output  1  one-cycle pulse when rx_data_o updates.
- start_o  output  1  one-cycle pulse on addressed START (address matched, either direction).
- stop_o  output  1  one-cycle pulse on STOP while addressed.
- rw_o  output  1  R/W bit of the current addressed transfer (1 = read).
- busy_o  output  1  high from addressed START until STOP or non-matching repeated START.

Behaviour:
- Reset values: all outputs 0, sda_io = 'z', state Idle, shift register 0, bit counter 0.
- Bus conditioning:
  - scl_io and sda_io pass through SYNC_STAGES flip-flops, then a one-flop delay for edge detection.
  - scl_rise / scl_fall are single-cycle strobes from the synchronized SCL.
- Bus conditions:
  - START: synchronized SDA falls while synchronized SCL is high.
  - STOP: synchronized SDA rises while synchronized SCL is high.
  - START and STOP are evaluated every cycle, in any state.
- START or repeated START:
  - Go to Addr; clear bit counter; release SDA.
  - busy_o is cleared if not re-addressed.
- STOP:
  - Go to Idle; release SDA.
  - Pulse stop_o if busy_o was high; clear busy_o.
- Sampling and driving:
  - SDA is sampled on scl_rise.
  - SDA drive changes only on scl_fall, so the drive updates SYNC_STAGES+1 clocks after the physical falling edge.
- States:
  - Idle: wait for START.
  - Addr: shift 8 bits MSB-first on scl_rise; after bit 8, compare bits[7:1] to ADDR.
    - On match, go to AddrAck on the next scl_fall.
    - On mismatch, go to Ignore.
  - AddrAck: drive SDA low for one SCL period (scl_fall to scl_fall).
    - On entry, latch rw_o, pulse start_o, set busy_o.
    - If rw = 1, pulse tx_req_o on the scl_rise of the ACK bit.
    - Exit to WrData (rw = 0) or RdData (rw = 1).
  - WrData: shift 8 bits on scl_rise; after bit 8, load rx_data_o, pulse rx_valid_o, go to WrAck.
  - WrAck: drive SDA low for one SCL period, then WrData. Every written byte is ACKed.
  - RdData:
    - On entry scl_fall, load tx_data_i into the shift register and present the MSB.
    - Shift on each subsequent scl_fall.
    - After 8 bits, release SDA and go to RdAck.
  - RdAck: sample master ACK on scl_rise.
    - ACK (0): pulse tx_req_o in the same cycle, then go to RdData on scl_fall.
    - NACK (1): go to Ignore.
  - Ignore: SDA released; wait for START or STOP.
- tx_data_i is held by user logic from tx_req_o until the next scl_fall; that window is at least half an SCL period.
- Bit counter is 4 bits and counts 0..8; it never wraps mid-byte because START clears it.
- Simultaneous START detection and scl_fall in the same cycle: START wins.
- SCL/SDA glitches shorter than SYNC_STAGES cycles are not filtered; bus timing is the master's responsibility.
- Asynchronous reset mid-transfer: SDA released immediately (combinational from state), all outputs return to reset values.

Decomposition:
- i2c_pkg contains:
  - state enum i2c_target_state_e: Idle, Addr, AddrAck, WrData, WrAck, RdData, RdAck, Ignore.
  - shared command constants START_CMD..RESTART_CMD, reused by the master.
- Sub-module i2c_sync_edge:
  - SYNC_STAGES synchronizer plus rise/fall detection.
  - Instantiated twice, once for SCL and once for SDA.
  - Outputs: level, rise, fall.

Test Plan:
- Write, matched address: i2c_master (dvsr_i = 16'd25) sends START, 0x84, 0xA5, 0x3C, STOP.
  - Target ACKs all three bytes (master ack_o = 0).
  - rx_valid_o pulses twice with rx_data_o = 0xA5 then 0x3C.
  - start_o and stop_o pulse once each; rw_o = 0.
- Address mismatch: START, 0x86, 0xFF, STOP.
  - Master sees NACK (ack_o = 1).
  - No rx_valid_o, start_o or busy_o activity; sda_io never driven.
- Read: START, 0x85, then the master reads with ACK and finally NACK.
  - User answers successive tx_req_o pulses with 0x5A and 0xC3.
  - Master dout_o = 0x5A, then 0xC3.
  - After the NACK, tx_req_o pulses exactly twice in total and the target releases SDA.
- Repeated START direction change: START, 0x84, 0x11, RESTART, 0x85, read one byte (tx_data_i = 0x77) with NACK, STOP.
  - rx_data_o = 0x11; rw_o goes 0 then 1; start_o pulses twice; master reads 0x77.
- Reset mid-byte: assert rst_i during bit 4 of a read byte.
  - sda_io = 'z' within the same cycle; busy_o = 0.
  - A subsequent write START, 0x84, 0x01, STOP works normally with rx_data_o = 0x01.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states and the command codes the
// i2c_master also uses to sequence bus operations.
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_RD_DATA,
      ST_RD_ACK,
      ST_IGNORE
   } i2c_target_state_e;

   localparam logic [2:0] START_CMD   = 3'd0;
   localparam logic [2:0] WR_CMD      = 3'd1;
   localparam logic [2:0] RD_CMD      = 3'd2;
   localparam logic [2:0] STOP_CMD    = 3'd3;
   localparam logic [2:0] RESTART_CMD = 3'd4;

   // Bit counter value once a full byte has been shifted in.
   localparam logic [3:0] BYTE_DONE_CNT = 4'd8;
   localparam logic [3:0] RD_LAST_CNT   = 4'd7;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one bus line, plus a delay flop to derive
// single-cycle rise/fall strobes from the synchronized level.
module i2c_sync_edge
   import i2c_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Reset to the idle-bus level so leaving reset on a quiet bus makes no edges.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/i2c_target.sv
// 7-bit-address I2C target: oversamples SCL/SDA on clk_i, ACKs its address
// and every written byte, and serves read bytes fetched through tx_req_o.
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] ADDR        = 7'h42,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   inout  wire        scl_io,
   inout  wire        sda_io,
   input  logic [7:0] tx_data_i,
   output logic       tx_req_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   output logic       start_o,
   output logic       stop_o,
   output logic       rw_o,
   output logic       busy_o
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;
   logic start_det, stop_det;
   logic sda_drive;

   i2c_target_state_e state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       tx_req_q, tx_req_d;
   logic       start_q, start_d;
   logic       stop_q, stop_d;
   logic       rw_q, rw_d;
   logic       busy_q, busy_d;

   i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .async_i (scl_io),
      .level_o (scl_lvl),
      .rise_o  (scl_rise),
      .fall_o  (scl_fall)
   );

   i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .async_i (sda_io),
      .level_o (sda_lvl),
      .rise_o  (sda_rise),
      .fall_o  (sda_fall)
   );

   assign start_det = sda_fall & scl_lvl;
   assign stop_det  = sda_rise & scl_lvl;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         cnt_q      <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         tx_req_q   <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
         rw_q       <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_req_q   <= tx_req_d;
         start_q    <= start_d;
         stop_q     <= stop_d;
         rw_q       <= rw_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      tx_req_d   = 1'b0;
      start_d    = 1'b0;
      stop_d     = 1'b0;
      rw_d       = rw_q;
      busy_d     = busy_q;

      // Bus conditions override any bit-level activity in the same cycle.
      if (start_det) begin
         state_d = ST_ADDR;
         shift_d = '0;
         cnt_d   = '0;
      end else if (stop_det) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         stop_d  = busy_q;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_ADDR: begin
               if (scl_rise && (cnt_q < BYTE_DONE_CNT)) begin
                  shift_d = {shift_q[6:0], sda_lvl};
                  cnt_d   = cnt_q + 4'd1;
               end else if (scl_fall && (cnt_q == BYTE_DONE_CNT)) begin
                  cnt_d = '0;
                  if (shift_q[7:1] == ADDR) begin
                     state_d = ST_ADDR_ACK;
                     rw_d    = shift_q[0];
                     start_d = 1'b1;
                     busy_d  = 1'b1;
                  end else begin
                     state_d = ST_IGNORE;
                     busy_d  = 1'b0;
                  end
               end
            end
            ST_ADDR_ACK: begin
               if (scl_rise && rw_q) begin
                  tx_req_d = 1'b1;
               end else if (scl_fall) begin
                  cnt_d = '0;
                  if (rw_q) begin
                     state_d = ST_RD_DATA;
                     shift_d = tx_data_i;
                  end else begin
                     state_d = ST_WR_DATA;
                  end
               end
            end
            ST_WR_DATA: begin
               if (scl_rise && (cnt_q < BYTE_DONE_CNT)) begin
                  shift_d = {shift_q[6:0], sda_lvl};
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == RD_LAST_CNT) begin
                     rx_data_d  = {shift_q[6:0], sda_lvl};
                     rx_valid_d = 1'b1;
                  end
               end else if (scl_fall && (cnt_q == BYTE_DONE_CNT)) begin
                  state_d = ST_WR_ACK;
                  cnt_d   = '0;
               end
            end
            ST_WR_ACK: begin
               if (scl_fall) begin
                  state_d = ST_WR_DATA;
               end
            end
            ST_RD_DATA: begin
               // The entry fall presented bit 7; seven more falls present the rest.
               if (scl_fall) begin
                  if (cnt_q == RD_LAST_CNT) begin
                     state_d = ST_RD_ACK;
                     cnt_d   = '0;
                  end else begin
                     shift_d = {shift_q[6:0], 1'b0};
                     cnt_d   = cnt_q + 4'd1;
                  end
               end
            end
            ST_RD_ACK: begin
               if (scl_rise) begin
                  if (!sda_lvl) begin
                     tx_req_d = 1'b1;
                  end else begin
                     state_d = ST_IGNORE;
                  end
               end else if (scl_fall) begin
                  state_d = ST_RD_DATA;
                  shift_d = tx_data_i;
                  cnt_d   = '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Drive is decoded from state so an asynchronous reset frees SDA at once.
   assign sda_drive = (state_q == ST_ADDR_ACK) || (state_q == ST_WR_ACK) ||
                      ((state_q == ST_RD_DATA) && !shift_q[7]);
   assign sda_io    = sda_drive ? 1'b0 : 1'bz;

   assign tx_req_o   = tx_req_q;
   assign rx_data_o  = rx_data_q;
   assign rx_valid_o = rx_valid_q;
   assign start_o    = start_q;
   assign stop_o     = stop_q;
   assign rw_o       = rw_q;
   assign busy_o     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged bus master plus a transaction-level
// model of which bytes get ACKed, delivered and read back.
module tb_i2c_target;

   localparam logic [6:0] ADDR = 7'h42;
   localparam int         Q    = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       m_scl = 1'b1;
   logic       m_sda_low = 1'b0;
   logic [7:0] tx_data = 8'h00;
   wire        scl_bus;
   wire        sda_bus;
   logic       tx_req_o, rx_valid_o, start_o, stop_o, rw_o, busy_o;
   logic [7:0] rx_data_o;

   int total = 0;
   int bad = 0;
   int n_rxv = 0, n_start = 0, n_stop = 0, n_txreq = 0, n_drive = 0;
   logic [7:0] rx_seen[$];
   logic [7:0] tx_q[$];

   always #5 clk = ~clk;

   assign scl_bus = m_scl;
   assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
   pullup (sda_bus);

   i2c_target #(.ADDR(ADDR), .SYNC_STAGES(2)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .scl_io     (scl_bus),
      .sda_io     (sda_bus),
      .tx_data_i  (tx_data),
      .tx_req_o   (tx_req_o),
      .rx_data_o  (rx_data_o),
      .rx_valid_o (rx_valid_o),
      .start_o    (start_o),
      .stop_o     (stop_o),
      .rw_o       (rw_o),
      .busy_o     (busy_o)
   );

   // User side of the target plus pulse counters, all sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rx_valid_o) begin
            n_rxv++;
            rx_seen.push_back(rx_data_o);
         end
         if (start_o) n_start++;
         if (stop_o) n_stop++;
         if (tx_req_o) begin
            n_txreq++;
            tx_data = (tx_q.size() > 0) ? tx_q.pop_front() : 8'h00;
         end
         if (!m_sda_low && (sda_bus == 1'b0)) n_drive++;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "simulation time limit reached");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick_q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic bit_cycle(input logic drive_low, output logic sampled);
      m_sda_low = drive_low;
      tick_q();
      m_scl = 1'b1;
      tick_q();
      sampled = sda_bus;
      tick_q();
      m_scl = 1'b0;
      tick_q();
   endtask

   task automatic bus_start();
      m_sda_low = 1'b1;
      tick_q();
      m_scl = 1'b0;
      tick_q();
   endtask

   task automatic bus_restart();
      m_sda_low = 1'b0;
      tick_q();
      m_scl = 1'b1;
      tick_q();
      m_sda_low = 1'b1;
      tick_q();
      m_scl = 1'b0;
      tick_q();
   endtask

   task automatic bus_stop();
      m_sda_low = 1'b1;
      tick_q();
      m_scl = 1'b1;
      tick_q();
      m_sda_low = 1'b0;
      tick_q();
      tick_q();
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_cycle(!b[i], s);
      bit_cycle(1'b0, ack);
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) bit_cycle(1'b0, d[i]);
      bit_cycle(!nack, s);
   endtask

   // One complete START..STOP transaction, judged purely by address match,
   // direction and payload.
   task automatic xfer(input logic [6:0] a, input logic rd, input int len,
                       input logic [23:0] data, input string tag);
      int s0, p0, v0, t0, d0, q0;
      logic ack, match;
      logic [7:0] d;
      match = (a == ADDR);
      s0 = n_start; p0 = n_stop; v0 = n_rxv; t0 = n_txreq; d0 = n_drive;
      q0 = rx_seen.size();
      if (rd) for (int i = 0; i < len; i++) tx_q.push_back(data[8*i +: 8]);
      bus_start();
      write_byte({a, rd}, ack);
      check({tag, " addr_ack"}, 32'(ack), 32'(!match));
      if (match && rd) begin
         for (int i = 0; i < len; i++) begin
            read_byte(i == len - 1, d);
            check({tag, " rd_data"}, 32'(d), 32'(data[8*i +: 8]));
         end
      end else if (!rd) begin
         for (int i = 0; i < len; i++) begin
            write_byte(data[8*i +: 8], ack);
            check({tag, " data_ack"}, 32'(ack), 32'(!match));
         end
      end
      check({tag, " busy_mid"}, 32'(busy_o), 32'(match));
      if (match) check({tag, " rw"}, 32'(rw_o), 32'(rd));
      bus_stop();
      check({tag, " start_cnt"}, 32'(n_start - s0), 32'(match));
      check({tag, " stop_cnt"}, 32'(n_stop - p0), 32'(match));
      check({tag, " rxv_cnt"}, 32'(n_rxv - v0), (match && !rd) ? 32'(len) : 32'd0);
      check({tag, " txreq_cnt"}, 32'(n_txreq - t0), (match && rd) ? 32'(len) : 32'd0);
      check({tag, " busy_end"}, 32'(busy_o), 32'd0);
      check({tag, " sda_free"}, 32'(sda_bus), 32'd1);
      if (match && !rd) begin
         for (int i = 0; i < len; i++)
            check({tag, " rx_byte"}, 32'(rx_seen[q0 + i]), 32'(data[8*i +: 8]));
      end
      if (!match) check({tag, " no_drive"}, 32'(n_drive - d0), 32'd0);
      tx_q.delete();
      $display("xfer %s addr=%02h rd=%0d len=%0d data=%06h match=%0d", tag, a, rd, len, data, match);
   endtask

   initial begin
      logic ack;
      logic s;
      logic [7:0] d;
      int s0, p0;

      repeat (3) @(negedge clk);
      check("rst sda", 32'(sda_bus), 32'd1);
      check("rst busy", 32'(busy_o), 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("reset outs", {tx_req_o, rx_valid_o, start_o, stop_o, rw_o, busy_o, rx_data_o}, 32'd0);

      xfer(ADDR, 1'b0, 2, 24'h003CA5, "write");
      xfer(7'h43, 1'b0, 1, 24'h0000FF, "mismatch");
      xfer(ADDR, 1'b1, 2, 24'h00C35A, "read");

      // Direction change through a repeated START.
      s0 = n_start;
      bus_start();
      write_byte(8'h84, ack);
      check("rs addr_w ack", 32'(ack), 32'd0);
      write_byte(8'h11, ack);
      check("rs data ack", 32'(ack), 32'd0);
      check("rs rx_data", 32'(rx_data_o), 32'h11);
      check("rs rw0", 32'(rw_o), 32'd0);
      tx_q.push_back(8'h77);
      bus_restart();
      write_byte(8'h85, ack);
      check("rs addr_r ack", 32'(ack), 32'd0);
      check("rs rw1", 32'(rw_o), 32'd1);
      read_byte(1'b1, d);
      check("rs rd_data", 32'(d), 32'h77);
      bus_stop();
      check("rs start_cnt", 32'(n_start - s0), 32'd2);
      $display("xfer restart w 0x11 then r 0x77");

      // Repeated START to another address drops busy without a stop_o.
      p0 = n_stop;
      bus_start();
      write_byte(8'h84, ack);
      check("rs_miss busy_before", 32'(busy_o), 32'd1);
      bus_restart();
      write_byte(8'h86, ack);
      check("rs_miss ack", 32'(ack), 32'd1);
      check("rs_miss busy_after", 32'(busy_o), 32'd0);
      bus_stop();
      check("rs_miss stop_cnt", 32'(n_stop - p0), 32'd0);
      $display("xfer restart to foreign address");

      // Reset while the target is driving bit 4 of a read byte.
      tx_q.push_back(8'h00);
      bus_start();
      write_byte(8'h85, ack);
      check("rst_mid ack", 32'(ack), 32'd0);
      for (int i = 0; i < 3; i++) bit_cycle(1'b0, s);
      check("rst_mid driving", 32'(sda_bus), 32'd0);
      rst = 1'b1;
      #1;
      check("rst_mid sda_free", 32'(sda_bus), 32'd1);
      check("rst_mid busy", 32'(busy_o), 32'd0);
      check("rst_mid rw", 32'(rw_o), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      tx_q.delete();
      tick_q();
      m_scl = 1'b1;
      tick_q();
      tick_q();
      $display("xfer reset during read bit 4");
      xfer(ADDR, 1'b0, 1, 24'h000001, "post_rst");

      for (int n = 0; n < 10; n++) begin
         logic [6:0] a;
         a = ($urandom_range(0, 2) == 0) ? 7'($urandom) : ADDR;
         xfer(a, 1'($urandom_range(0, 1)), $urandom_range(1, 3), 24'($urandom), "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
